// File: rtl/ppi_8255.sv
// ppi_8255: simplified 8255-style programmable peripheral interface (Mode 0 basic I/O and Port C bit set/reset only).
// Latency: a captured write reaches the port pins in the cycle after the capturing edge; host reads are combinational.
// Backpressure: none; every host strobe completes immediately, and an illegal RD_+WR_ overlap is simply ignored.
//
// Ports:
//   CLK, RESET        rising-edge clock, synchronous active-high reset
//   PORTA/PORTB/PORTC bidirectional peripheral pins (PORTC split into [7:4] and [3:0] nibbles)
//   PORTD             bidirectional host data bus
//   CS_, RD_, WR_     active-low chip select, read strobe and write strobe
//   A                 register select: 0 port A, 1 port B, 2 port C, 3 control
module ppi_8255 (
   input  logic       CLK,
   input  logic       RESET,
   inout  wire  [7:0] PORTA,
   inout  wire  [7:0] PORTB,
   inout  wire  [7:0] PORTC,
   inout  wire  [7:0] PORTD,
   input  logic       RD_,
   input  logic       WR_,
   input  logic [1:0] A,
   input  logic       CS_
);

   // Direction bits: 1 = port (or nibble) is an input and its pins are released.
   logic       dir_a;
   logic       dir_cu;
   logic       dir_b;
   logic       dir_cl;
   logic [7:0] lat_a;
   logic [7:0] lat_b;
   logic [7:0] lat_c;

   logic       wr_vld;
   logic       rd_vld;
   logic [7:0] rd_dat;

   // RD_ and WR_ low together is illegal, so each strobe only counts with the other one high.
   assign wr_vld = !CS_ && !WR_ && RD_;
   assign rd_vld = !CS_ && !RD_ && WR_ && (A != 2'd3);

   always_ff @(posedge CLK) begin
      if (RESET) begin
         dir_a  <= 1'b1;
         dir_cu <= 1'b1;
         dir_b  <= 1'b1;
         dir_cl <= 1'b1;
         lat_a  <= 8'h00;
         lat_b  <= 8'h00;
         lat_c  <= 8'h00;
      end else if (wr_vld) begin
         case (A)
            2'd0: lat_a <= PORTD;
            2'd1: lat_b <= PORTD;
            2'd2: lat_c <= PORTD;
            default: begin
               if (PORTD[7]) begin
                  // Mode set: only Mode 0 exists, so the mode-select bits D6:D5 and D2 are dropped.
                  dir_a  <= PORTD[4];
                  dir_cu <= PORTD[3];
                  dir_b  <= PORTD[1];
                  dir_cl <= PORTD[0];
                  lat_a  <= 8'h00;
                  lat_b  <= 8'h00;
                  lat_c  <= 8'h00;
               end else begin
                  // Bit set/reset: D3:D1 picks the Port C bit, D0 is its new value.
                  lat_c[PORTD[3:1]] <= PORTD[0];
               end
            end
         endcase
      end
   end

   assign PORTA      = dir_a  ? 8'hzz : lat_a;
   assign PORTB      = dir_b  ? 8'hzz : lat_b;
   assign PORTC[7:4] = dir_cu ? 4'hz  : lat_c[7:4];
   assign PORTC[3:0] = dir_cl ? 4'hz  : lat_c[3:0];

   // Input ports return the live pins (undriven pins pass through untouched); outputs return their latch.
   always_comb begin
      rd_dat = 8'h00;
      case (A)
         2'd0:    rd_dat = dir_a ? PORTA : lat_a;
         2'd1:    rd_dat = dir_b ? PORTB : lat_b;
         2'd2:    rd_dat = {dir_cu ? PORTC[7:4] : lat_c[7:4],
                            dir_cl ? PORTC[3:0] : lat_c[3:0]};
         default: rd_dat = 8'h00;
      endcase
   end

   assign PORTD = rd_vld ? rd_dat : 8'hzz;

endmodule

// File: tb/tb_ppi_8255.sv
// tb_ppi_8255: self-checking bench for ppi_8255 with a wire-level behavioural model.
// Latency: model state advances on each rising edge; all outputs are compared on the falling edge.
// Backpressure: none; the bench drives the host strobes freely every cycle.
module tb_ppi_8255;

   logic       clk = 1'b0;
   logic       rst;
   logic       cs_n;
   logic       rd_n;
   logic       wr_n;
   logic [1:0] a;
   logic [7:0] d;
   logic [7:0] ext_a;
   logic [7:0] ext_b;
   logic [7:0] ext_c;

   wire  [7:0] porta;
   wire  [7:0] portb;
   wire  [7:0] portc;
   wire  [7:0] portd;

   // Behavioural model: which port halves are inputs and what each output latch holds.
   bit         m_in_a;
   bit         m_in_b;
   bit         m_in_cu;
   bit         m_in_cl;
   logic [7:0] m_lat [3];

   int         n_tests = 0;
   int         n_fail  = 0;
   bit         chk_en  = 1'b0;

   always #5 clk = ~clk;

   ppi_8255 dut (
      .CLK   (clk),
      .RESET (rst),
      .PORTA (porta),
      .PORTB (portb),
      .PORTC (portc),
      .PORTD (portd),
      .RD_   (rd_n),
      .WR_   (wr_n),
      .A     (a),
      .CS_   (cs_n)
   );

   // The host bus is owned by the chip only during a legal read of ports A..C.
   wire reading = !cs_n && !rd_n && wr_n && (a != 2'd3);

   // The outside world drives whatever the model says is an input, and the host drives
   // the data bus whenever the chip should not; reading those values back proves high-Z.
   assign porta      = m_in_a  ? ext_a      : 8'hzz;
   assign portb      = m_in_b  ? ext_b      : 8'hzz;
   assign portc[7:4] = m_in_cu ? ext_c[7:4] : 4'hz;
   assign portc[3:0] = m_in_cl ? ext_c[3:0] : 4'hz;
   assign portd      = reading ? 8'hzz      : d;

   // Value that must appear on a port's wires: the peripheral's value for inputs, the latch for outputs.
   function automatic logic [7:0] exp_pin(input int p);
      logic [7:0] v;
      case (p)
         0:       v = m_in_a ? ext_a : m_lat[0];
         1:       v = m_in_b ? ext_b : m_lat[1];
         default: begin
            v[7:4] = m_in_cu ? ext_c[7:4] : m_lat[2][7:4];
            v[3:0] = m_in_cl ? ext_c[3:0] : m_lat[2][3:0];
         end
      endcase
      return v;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Model update at the capturing edge, from the bus values the chip also saw.
   task automatic model_clock();
      if (rst) begin
         m_in_a  = 1'b1;
         m_in_b  = 1'b1;
         m_in_cu = 1'b1;
         m_in_cl = 1'b1;
         for (int i = 0; i < 3; i++) m_lat[i] = 8'h00;
      end else if (!cs_n && !wr_n && rd_n) begin
         if (a != 2'd3) begin
            m_lat[a] = d;
         end else if (d[7]) begin
            m_in_a  = d[4];
            m_in_cu = d[3];
            m_in_b  = d[1];
            m_in_cl = d[0];
            for (int i = 0; i < 3; i++) m_lat[i] = 8'h00;
         end else begin
            m_lat[2][d[3:1]] = d[0];
         end
      end
   endtask

   // Single compare process: every port and the host bus, every cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("porta", porta, exp_pin(0));
         chk("portb", portb, exp_pin(1));
         chk("portc", portc, exp_pin(2));
         chk("portd", portd, reading ? exp_pin(int'(a)) : d);
      end
   end

   task automatic bus(input logic r, input logic c, input logic rv, input logic wv,
                      input logic [1:0] aa, input logic [7:0] dd);
      rst  = r;
      cs_n = c;
      rd_n = rv;
      wr_n = wv;
      a    = aa;
      d    = dd;
   endtask

   task automatic tick();
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic idle();
      bus(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00);
   endtask

   task automatic wr(input logic [1:0] aa, input logic [7:0] dd);
      bus(1'b0, 1'b0, 1'b1, 1'b0, aa, dd);
      tick();
      idle();
   endtask

   // Combinational read: the bus must carry the value within the same cycle.
   task automatic rd_chk(input string name, input logic [1:0] aa, input logic [7:0] exp);
      bus(1'b0, 1'b0, 1'b0, 1'b1, aa, 8'h00);
      @(negedge clk);
      chk(name, portd, exp);
      tick();
      idle();
   endtask

   task automatic pin_chk(input string name, input int p, input logic [7:0] exp);
      @(negedge clk);
      case (p)
         0:       chk(name, porta, exp);
         1:       chk(name, portb, exp);
         default: chk(name, portc, exp);
      endcase
   endtask

   initial begin
      m_in_a  = 1'b1;
      m_in_b  = 1'b1;
      m_in_cu = 1'b1;
      m_in_cl = 1'b1;
      for (int i = 0; i < 3; i++) m_lat[i] = 8'h00;
      ext_a = 8'h00;
      ext_b = 8'h00;
      ext_c = 8'h00;

      bus(1'b1, 1'b1, 1'b1, 1'b1, 2'd0, 8'h00);
      tick();
      tick();
      idle();
      chk_en = 1'b1;

      // Reset state: every port is an input, so reads return the peripheral's value.
      ext_a = 8'h5A;
      rd_chk("reset_rd_a", 2'd0, 8'h5A);

      // All ports as inputs.
      wr(2'd3, 8'h9B);
      ext_a = 8'hE7;
      rd_chk("in_rd_a", 2'd0, 8'hE7);
      ext_b = 8'hC3;
      rd_chk("in_rd_b", 2'd1, 8'hC3);
      ext_c = 8'h81;
      rd_chk("in_rd_c", 2'd2, 8'h81);

      // All ports as outputs.
      wr(2'd3, 8'h80);
      wr(2'd0, 8'h7E);
      pin_chk("out_a", 0, 8'h7E);
      wr(2'd1, 8'h3C);
      pin_chk("out_b", 1, 8'h3C);
      wr(2'd2, 8'h18);
      pin_chk("out_c", 2, 8'h18);

      // Port C bit set/reset.
      wr(2'd3, 8'h80);
      wr(2'd3, 8'h0F);
      pin_chk("bsr_set7", 2, 8'h80);
      wr(2'd3, 8'h01);
      pin_chk("bsr_set0", 2, 8'h81);
      wr(2'd3, 8'h0E);
      pin_chk("bsr_clr7", 2, 8'h01);
      wr(2'd3, 8'h00);
      pin_chk("bsr_clr0", 2, 8'h00);
      for (int i = 0; i < 8; i++) begin
         logic [7:0] cmd;
         logic [8:0] mask;
         cmd  = 8'h01 | 8'(i << 1);
         mask = 9'((1 << (i + 1)) - 1);
         wr(2'd3, cmd);
         pin_chk("bsr_sweep", 2, mask[7:0]);
      end
      wr(2'd0, 8'hA5);
      pin_chk("bsr_mode_kept", 0, 8'hA5);

      // Upper Port C nibble input, lower nibble output.
      wr(2'd3, 8'h88);
      wr(2'd2, 8'hFF);
      ext_c = 8'h50;
      pin_chk("split_c_pins", 2, 8'h5F);
      rd_chk("split_c_rd", 2'd2, 8'h5F);

      // Reset releases all ports and beats a simultaneous write.
      wr(2'd3, 8'h80);
      wr(2'd0, 8'h11);
      wr(2'd1, 8'h22);
      wr(2'd2, 8'h33);
      bus(1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 8'h80);
      tick();
      idle();
      ext_a = 8'h96;
      ext_b = 8'h69;
      ext_c = 8'hC5;
      pin_chk("rst_rel_a", 0, 8'h96);
      pin_chk("rst_rel_c", 2, 8'hC5);
      rd_chk("rst_rd_b", 2'd1, 8'h69);
      wr(2'd3, 8'h80);
      pin_chk("rst_lat_a", 0, 8'h00);
      pin_chk("rst_lat_b", 1, 8'h00);
      pin_chk("rst_lat_c", 2, 8'h00);

      // Deselected write, illegal strobe overlap, unreadable control register.
      wr(2'd0, 8'h3C);
      bus(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 8'hC3);
      tick();
      idle();
      pin_chk("cs_blocks_wr", 0, 8'h3C);
      bus(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h5A);
      @(negedge clk);
      chk("illegal_bus_z", portd, 8'h5A);
      tick();
      idle();
      pin_chk("illegal_no_wr", 0, 8'h3C);
      bus(1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 8'hA6);
      @(negedge clk);
      chk("ctrl_rd_z", portd, 8'hA6);
      tick();
      idle();

      // Randomized traffic, checked every cycle by the compare process.
      for (int i = 0; i < 2000; i++) begin
         logic r, c, rv, wv;
         int   op;
         r  = ($urandom_range(0, 79) == 0);
         c  = ($urandom_range(0, 4) == 0);
         op = int'($urandom_range(0, 7));
         rv = 1'b1;
         wv = 1'b1;
         if (op < 3) begin
            wv = 1'b0;
         end else if (op < 6) begin
            rv = 1'b0;
         end else if (op == 6) begin
            rv = 1'b0;
            wv = 1'b0;
         end
         ext_a = 8'($urandom);
         ext_b = 8'($urandom);
         ext_c = 8'($urandom);
         bus(r, c, rv, wv, 2'($urandom), 8'($urandom));
         tick();
      end
      idle();
      @(negedge clk);
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
